// File: rtl/adc_sample_averager_if.sv
// Bus between an ADC front end, the sample averager and the result consumer.
// The averager sits on the slave side; the ADC/consumer side drives the master modport.
interface adc_sample_averager_if #(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 4
) ();
  logic              ENABLE;
  logic [DATA_W-1:0] IN_DATA;
  logic              IN_VALID;
  logic              AVG_READY;
  logic              CLR_OVR;
  logic [DATA_W-1:0] AVG;
  logic [DATA_W-1:0] AVG_MAX;
  logic [DATA_W-1:0] AVG_MIN;
  logic              AVG_VALID;
  logic              OVERRUN;
  logic [LOG2_N:0]   FILL;

  modport master (
    output ENABLE, IN_DATA, IN_VALID, AVG_READY, CLR_OVR,
    input  AVG, AVG_MAX, AVG_MIN, AVG_VALID, OVERRUN, FILL
  );

  modport slave (
    input  ENABLE, IN_DATA, IN_VALID, AVG_READY, CLR_OVR,
    output AVG, AVG_MAX, AVG_MIN, AVG_VALID, OVERRUN, FILL
  );
endinterface

// File: rtl/adc_sample_averager.sv
// Block averager: accumulates 2^LOG2_N ADC samples and publishes mean, max and min
// through a single-entry output register with valid/ready and a sticky overrun flag.
module adc_sample_averager #(
  parameter int LOG2_N = 4,
  parameter int DATA_W = 16
) (
  input  logic                 CLK,
  input  logic                 rst,
  adc_sample_averager_if.slave bus
);
  localparam int ACC_W  = DATA_W + LOG2_N;
  localparam int FILL_W = LOG2_N + 1;
  localparam logic [FILL_W-1:0] LAST = FILL_W'((1 << LOG2_N) - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic [DATA_W-1:0] avg_max_q, avg_max_d;
  logic [DATA_W-1:0] avg_min_q, avg_min_d;
  logic              avg_valid_q, avg_valid_d;
  logic              overrun_q, overrun_d;

  logic              accept;
  logic              complete;
  logic [ACC_W-1:0]  sum;
  logic [DATA_W-1:0] samp_max;
  logic [DATA_W-1:0] samp_min;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    // A sample arriving on the edge where ENABLE drops is not accepted.
    accept   = (state_q == ACCUM) && bus.ENABLE && bus.IN_VALID;
    complete = accept && (fill_q == LAST);
    sum      = acc_q + ACC_W'(bus.IN_DATA);
    samp_max = (bus.IN_DATA > max_q) ? bus.IN_DATA : max_q;
    samp_min = (bus.IN_DATA < min_q) ? bus.IN_DATA : min_q;

    state_d     = bus.ENABLE ? ACCUM : IDLE;
    acc_d       = acc_q;
    fill_d      = fill_q;
    max_d       = max_q;
    min_d       = min_q;
    avg_d       = avg_q;
    avg_max_d   = avg_max_q;
    avg_min_d   = avg_min_q;
    avg_valid_d = avg_valid_q;
    overrun_d   = overrun_q;

    if ((state_q == IDLE) || !bus.ENABLE || complete) begin
      acc_d  = '0;
      fill_d = '0;
      max_d  = '0;
      min_d  = '1;
    end else if (accept) begin
      acc_d  = sum;
      fill_d = fill_q + FILL_W'(1);
      max_d  = samp_max;
      min_d  = samp_min;
    end

    // The register is free if empty or being drained on this same edge.
    if (complete && (!avg_valid_q || bus.AVG_READY)) begin
      avg_d       = sum[ACC_W-1:LOG2_N];
      avg_max_d   = samp_max;
      avg_min_d   = samp_min;
      avg_valid_d = 1'b1;
    end else if (avg_valid_q && bus.AVG_READY) begin
      avg_valid_d = 1'b0;
    end

    if (complete && avg_valid_q && !bus.AVG_READY) begin
      overrun_d = 1'b1;
    end else if (bus.CLR_OVR) begin
      overrun_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      fill_q      <= '0;
      max_q       <= '0;
      min_q       <= '1;
      avg_q       <= '0;
      avg_max_q   <= '0;
      avg_min_q   <= '0;
      avg_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      max_q       <= max_d;
      min_q       <= min_d;
      avg_q       <= avg_d;
      avg_max_q   <= avg_max_d;
      avg_min_q   <= avg_min_d;
      avg_valid_q <= avg_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.AVG       = avg_q;
  assign bus.AVG_MAX   = avg_max_q;
  assign bus.AVG_MIN   = avg_min_q;
  assign bus.AVG_VALID = avg_valid_q;
  assign bus.OVERRUN   = overrun_q;
  assign bus.FILL      = fill_q;
endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager: main instance with N=4, plus N=2, N=16 and N=1
// instances for truncation, full-scale and single-sample windows.
module tb_adc_sample_averager;
  logic CLK = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  adc_sample_averager_if #(.DATA_W(16), .LOG2_N(2)) m_if ();
  adc_sample_averager_if #(.DATA_W(16), .LOG2_N(1)) d1_if ();
  adc_sample_averager_if #(.DATA_W(16), .LOG2_N(4)) d4_if ();
  adc_sample_averager_if #(.DATA_W(16), .LOG2_N(0)) d0_if ();

  adc_sample_averager #(.LOG2_N(2), .DATA_W(16)) dut_m  (.CLK(CLK), .rst(rst), .bus(m_if));
  adc_sample_averager #(.LOG2_N(1), .DATA_W(16)) dut_d1 (.CLK(CLK), .rst(rst), .bus(d1_if));
  adc_sample_averager #(.LOG2_N(4), .DATA_W(16)) dut_d4 (.CLK(CLK), .rst(rst), .bus(d4_if));
  adc_sample_averager #(.LOG2_N(0), .DATA_W(16)) dut_d0 (.CLK(CLK), .rst(rst), .bus(d0_if));

  // One-cycle strobe into the main instance; returns on the negedge after the accepting edge.
  task automatic m_send(input logic [15:0] d);
    m_if.IN_DATA  = d;
    m_if.IN_VALID = 1'b1;
    @(negedge CLK);
    m_if.IN_VALID = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    m_if.ENABLE = 0; m_if.IN_DATA = 0; m_if.IN_VALID = 0; m_if.AVG_READY = 0; m_if.CLR_OVR = 0;
    d1_if.ENABLE = 0; d1_if.IN_DATA = 0; d1_if.IN_VALID = 0; d1_if.AVG_READY = 0; d1_if.CLR_OVR = 0;
    d4_if.ENABLE = 0; d4_if.IN_DATA = 0; d4_if.IN_VALID = 0; d4_if.AVG_READY = 0; d4_if.CLR_OVR = 0;
    d0_if.ENABLE = 0; d0_if.IN_DATA = 0; d0_if.IN_VALID = 0; d0_if.AVG_READY = 0; d0_if.CLR_OVR = 0;
    @(negedge CLK);
    n_cmp++;
    if ({m_if.AVG, m_if.AVG_MAX, m_if.AVG_MIN, m_if.AVG_VALID, m_if.OVERRUN, m_if.FILL} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got avg=%0d max=%0d min=%0d v=%b ovr=%b fill=%0d, want all 0",
               m_if.AVG, m_if.AVG_MAX, m_if.AVG_MIN, m_if.AVG_VALID, m_if.OVERRUN, m_if.FILL);
    end
    // Release with a strobe already present: the first edge only leaves IDLE.
    rst = 1'b1;
    m_if.ENABLE = 1; d1_if.ENABLE = 1; d4_if.ENABLE = 1; d0_if.ENABLE = 1;
    m_if.IN_DATA = 16'd77; m_if.IN_VALID = 1'b1;
    @(negedge CLK);
    m_if.IN_VALID = 1'b0;
    n_cmp++;
    if (m_if.FILL !== 3'd0) begin
      n_err++; $display("FAIL first_edge_after_release: got fill=%0d want 0", m_if.FILL);
    end
  endtask

  task automatic test_basic;
    m_if.AVG_READY = 1'b1;
    m_send(16'd100); m_send(16'd200); m_send(16'd300);
    n_cmp++;
    if ({m_if.FILL, m_if.AVG_VALID} !== {3'd3, 1'b0}) begin
      n_err++; $display("FAIL basic_partial: got fill=%0d v=%b want fill=3 v=0", m_if.FILL, m_if.AVG_VALID);
    end
    m_send(16'd400);
    n_cmp++;
    if ({m_if.AVG, m_if.AVG_MAX, m_if.AVG_MIN, m_if.AVG_VALID, m_if.FILL} !==
        {16'd250, 16'd400, 16'd100, 1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL basic_result: got avg=%0d max=%0d min=%0d v=%b fill=%0d want 250/400/100/1/0",
               m_if.AVG, m_if.AVG_MAX, m_if.AVG_MIN, m_if.AVG_VALID, m_if.FILL);
    end
    @(negedge CLK);
    n_cmp++;
    if (m_if.AVG_VALID !== 1'b0) begin
      n_err++; $display("FAIL basic_valid_one_cycle: got v=%b want 0", m_if.AVG_VALID);
    end
  endtask

  task automatic test_overrun;
    m_if.AVG_READY = 1'b0;
    repeat (4) m_send(16'd10);
    n_cmp++;
    if ({m_if.AVG, m_if.AVG_VALID} !== {16'd10, 1'b1}) begin
      n_err++; $display("FAIL overrun_first: got avg=%0d v=%b want 10/1", m_if.AVG, m_if.AVG_VALID);
    end
    repeat (4) m_send(16'd20);
    n_cmp++;
    if ({m_if.AVG, m_if.AVG_MAX, m_if.AVG_MIN, m_if.AVG_VALID, m_if.OVERRUN, m_if.FILL} !==
        {16'd10, 16'd10, 16'd10, 1'b1, 1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL overrun_kept: got avg=%0d max=%0d min=%0d v=%b ovr=%b fill=%0d want 10/10/10/1/1/0",
               m_if.AVG, m_if.AVG_MAX, m_if.AVG_MIN, m_if.AVG_VALID, m_if.OVERRUN, m_if.FILL);
    end
    m_if.CLR_OVR = 1'b1;
    @(negedge CLK);
    m_if.CLR_OVR = 1'b0;
    n_cmp++;
    if ({m_if.OVERRUN, m_if.AVG_VALID, m_if.AVG} !== {1'b0, 1'b1, 16'd10}) begin
      n_err++;
      $display("FAIL overrun_clear: got ovr=%b v=%b avg=%0d want 0/1/10", m_if.OVERRUN, m_if.AVG_VALID, m_if.AVG);
    end
  endtask

  task automatic test_set_wins;
    repeat (3) m_send(16'd30);
    m_if.CLR_OVR = 1'b1;
    m_send(16'd30);
    m_if.CLR_OVR = 1'b0;
    n_cmp++;
    if ({m_if.OVERRUN, m_if.AVG} !== {1'b1, 16'd10}) begin
      n_err++; $display("FAIL set_beats_clear: got ovr=%b avg=%0d want 1/10", m_if.OVERRUN, m_if.AVG);
    end
    m_if.CLR_OVR = 1'b1;
    @(negedge CLK);
    m_if.CLR_OVR = 1'b0;
  endtask

  task automatic test_simultaneous;
    repeat (3) m_send(16'd40);
    m_if.AVG_READY = 1'b1;
    m_send(16'd60);
    n_cmp++;
    if ({m_if.AVG, m_if.AVG_MAX, m_if.AVG_MIN, m_if.AVG_VALID, m_if.OVERRUN} !==
        {16'd45, 16'd60, 16'd40, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL simultaneous_load: got avg=%0d max=%0d min=%0d v=%b ovr=%b want 45/60/40/1/0",
               m_if.AVG, m_if.AVG_MAX, m_if.AVG_MIN, m_if.AVG_VALID, m_if.OVERRUN);
    end
    @(negedge CLK);
    n_cmp++;
    if (m_if.AVG_VALID !== 1'b0) begin
      n_err++; $display("FAIL simultaneous_drain: got v=%b want 0", m_if.AVG_VALID);
    end
  endtask

  task automatic test_interrupt;
    m_send(16'd5); m_send(16'd5);
    n_cmp++;
    if (m_if.FILL !== 3'd2) begin
      n_err++; $display("FAIL interrupt_partial: got fill=%0d want 2", m_if.FILL);
    end
    m_if.ENABLE = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if ({m_if.FILL, m_if.AVG_VALID, m_if.AVG, m_if.OVERRUN} !== {3'd0, 1'b0, 16'd45, 1'b0}) begin
      n_err++;
      $display("FAIL interrupt_discard: got fill=%0d v=%b avg=%0d ovr=%b want 0/0/45/0",
               m_if.FILL, m_if.AVG_VALID, m_if.AVG, m_if.OVERRUN);
    end
    m_if.ENABLE = 1'b1;
    @(negedge CLK);
    m_send(16'd3);
    m_if.ENABLE = 1'b0;
    m_send(16'd9);
    n_cmp++;
    if (m_if.FILL !== 3'd0) begin
      n_err++; $display("FAIL enable_fall_drop: got fill=%0d want 0", m_if.FILL);
    end
    m_if.ENABLE = 1'b1;
    @(negedge CLK);
    repeat (4) m_send(16'd8);
    n_cmp++;
    if ({m_if.AVG, m_if.AVG_VALID, m_if.FILL} !== {16'd8, 1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL interrupt_restart: got avg=%0d v=%b fill=%0d want 8/1/0", m_if.AVG, m_if.AVG_VALID, m_if.FILL);
    end
    @(negedge CLK);
  endtask

  task automatic test_async_reset;
    m_if.AVG_READY = 1'b0;
    repeat (4) m_send(16'd12);
    m_send(16'd1);
    n_cmp++;
    if ({m_if.AVG, m_if.AVG_VALID, m_if.FILL} !== {16'd12, 1'b1, 3'd1}) begin
      n_err++;
      $display("FAIL pre_reset_state: got avg=%0d v=%b fill=%0d want 12/1/1", m_if.AVG, m_if.AVG_VALID, m_if.FILL);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({m_if.AVG, m_if.AVG_MAX, m_if.AVG_MIN, m_if.AVG_VALID, m_if.OVERRUN, m_if.FILL} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got avg=%0d max=%0d min=%0d v=%b ovr=%b fill=%0d want all 0",
               m_if.AVG, m_if.AVG_MAX, m_if.AVG_MIN, m_if.AVG_VALID, m_if.OVERRUN, m_if.FILL);
    end
    @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
    m_if.AVG_READY = 1'b1;
    repeat (4) m_send(16'd2);
    n_cmp++;
    if ({m_if.AVG, m_if.AVG_VALID} !== {16'd2, 1'b1}) begin
      n_err++; $display("FAIL post_reset_window: got avg=%0d v=%b want 2/1", m_if.AVG, m_if.AVG_VALID);
    end
    @(negedge CLK);
  endtask

  // Sparse strobes as an ADC conversion stream would produce; one result per four strobes.
  task automatic test_integration;
    int pulses = 0;
    m_if.AVG_READY = 1'b1;
    for (int i = 0; i < 12; i++) begin
      m_send(16'(1000 + i));
      if (m_if.AVG_VALID) pulses++;
      for (int g = 0; g < 3; g++) begin
        @(negedge CLK);
        if (m_if.AVG_VALID) pulses++;
      end
    end
    n_cmp++;
    if (pulses !== 3) begin
      n_err++; $display("FAIL stream_pulse_count: got %0d want 3", pulses);
    end
    n_cmp++;
    if ({m_if.AVG, m_if.AVG_MAX, m_if.AVG_MIN} !== {16'd1009, 16'd1011, 16'd1008}) begin
      n_err++;
      $display("FAIL stream_last_window: got avg=%0d max=%0d min=%0d want 1009/1011/1008",
               m_if.AVG, m_if.AVG_MAX, m_if.AVG_MIN);
    end
  endtask

  task automatic test_truncation;
    d1_if.AVG_READY = 1'b0;
    d1_if.IN_DATA = 16'd1; d1_if.IN_VALID = 1'b1;
    @(negedge CLK);
    d1_if.IN_DATA = 16'd2;
    @(negedge CLK);
    d1_if.IN_VALID = 1'b0;
    n_cmp++;
    if ({d1_if.AVG, d1_if.AVG_MAX, d1_if.AVG_MIN, d1_if.AVG_VALID} !== {16'd1, 16'd2, 16'd1, 1'b1}) begin
      n_err++;
      $display("FAIL truncation: got avg=%0d max=%0d min=%0d v=%b want 1/2/1/1",
               d1_if.AVG, d1_if.AVG_MAX, d1_if.AVG_MIN, d1_if.AVG_VALID);
    end
  endtask

  task automatic test_full_scale;
    d4_if.AVG_READY = 1'b1;
    d4_if.IN_DATA = 16'hFFFF; d4_if.IN_VALID = 1'b1;
    repeat (15) @(negedge CLK);
    n_cmp++;
    if ({d4_if.FILL, d4_if.AVG_VALID} !== {5'd15, 1'b0}) begin
      n_err++; $display("FAIL full_scale_fill: got fill=%0d v=%b want 15/0", d4_if.FILL, d4_if.AVG_VALID);
    end
    @(negedge CLK);
    d4_if.IN_VALID = 1'b0;
    n_cmp++;
    if ({d4_if.AVG, d4_if.AVG_VALID, d4_if.FILL} !== {16'hFFFF, 1'b1, 5'd0}) begin
      n_err++;
      $display("FAIL full_scale_avg: got avg=%h v=%b fill=%0d want ffff/1/0", d4_if.AVG, d4_if.AVG_VALID, d4_if.FILL);
    end
  endtask

  task automatic test_single_sample;
    d0_if.AVG_READY = 1'b0;
    d0_if.IN_DATA = 16'h1234; d0_if.IN_VALID = 1'b1;
    @(negedge CLK);
    d0_if.IN_VALID = 1'b0;
    n_cmp++;
    if ({d0_if.AVG, d0_if.AVG_MAX, d0_if.AVG_MIN, d0_if.AVG_VALID} !== {16'h1234, 16'h1234, 16'h1234, 1'b1}) begin
      n_err++;
      $display("FAIL single_sample: got avg=%h max=%h min=%h v=%b want 1234 x3 /1",
               d0_if.AVG, d0_if.AVG_MAX, d0_if.AVG_MIN, d0_if.AVG_VALID);
    end
    d0_if.AVG_READY = 1'b1;
    d0_if.IN_DATA = 16'h0007; d0_if.IN_VALID = 1'b1;
    @(negedge CLK);
    d0_if.IN_VALID = 1'b0;
    n_cmp++;
    if ({d0_if.AVG, d0_if.AVG_VALID, d0_if.OVERRUN} !== {16'h0007, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL single_sample_handshake: got avg=%h v=%b ovr=%b want 0007/1/0",
               d0_if.AVG, d0_if.AVG_VALID, d0_if.OVERRUN);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_set_wins();
    test_simultaneous();
    test_interrupt();
    test_async_reset();
    test_integration();
    test_truncation();
    test_full_scale();
    test_single_sample();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/adc_sample_averager.md
ADC_SAMPLE_AVERAGER -- requirements
Module: adc_sample_averager

Interface
REQ-001 Parameter LOG2_N, default 4, legal range 0..8: the window is N = 2^LOG2_N samples.
REQ-002 Parameter DATA_W, default 16: the width of each ADC sample.
REQ-003 CLK  in  1  the single clock; all state is updated on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low.
REQ-005 ENABLE  in  1  averaging enable; while low, the window is held cleared.
REQ-006 IN_DATA  in  DATA_W  sample word, driven by the ADC interface RESULT output.
REQ-007 IN_VALID  in  1  one-cycle strobe marking IN_DATA valid, driven by the ADC interface VALID output.
REQ-008 AVG_READY  in  1  the downstream consumer accepts AVG when this and AVG_VALID are both high.
REQ-009 CLR_OVR  in  1  synchronous clear of OVERRUN.
REQ-010 AVG  out  DATA_W  window mean.
REQ-011 AVG_MAX  out  DATA_W  largest sample in the window.
REQ-012 AVG_MIN  out  DATA_W  smallest sample in the window.
REQ-013 AVG_VALID  out  1  output register holds an unconsumed result.
REQ-014 OVERRUN  out  1  sticky flag: a completed window was dropped.
REQ-015 FILL  out  LOG2_N+1  number of samples accumulated in the current window.

Function
REQ-016 The block SHALL have two states. IDLE is entered when ENABLE=0. ACCUM is entered when ENABLE=1, on the cycle after ENABLE rises.
REQ-017 In IDLE, the block SHALL hold the accumulator, FILL, the running max and the running min at their cleared values, and SHALL ignore IN_VALID.
REQ-018 The cleared values SHALL be: accumulator 0, FILL 0, running max 0, running min all-ones.
REQ-019 The accumulator SHALL be DATA_W+LOG2_N bits wide, unsigned, and SHALL never wrap.
REQ-020 In ACCUM, on each edge with IN_VALID=1, the block SHALL add IN_DATA to the accumulator, increment FILL, and update the running max and min.
REQ-021 When a sample is accepted with FILL=N-1, the block SHALL load the output registers on that same edge, as follows:
- AVG = (acc+IN_DATA) >> LOG2_N, truncated.
- AVG_MAX and AVG_MIN include that final sample.
REQ-022 On the edge of REQ-021, the block SHALL clear the accumulator, FILL, max and min, and AVG_VALID SHALL be 1 from the following cycle. Latency is one cycle from the final IN_VALID to AVG_VALID.
REQ-023 AVG_VALID SHALL clear on the edge where AVG_VALID=1 and AVG_READY=1.
REQ-024 While AVG_VALID=1, AVG, AVG_MAX and AVG_MIN SHALL remain stable.
REQ-025 If a window completes while AVG_VALID=1 and AVG_READY=0, the block SHALL:
- keep the old result,
- discard the new result,
- set OVERRUN,
- still restart the window.
REQ-026 If a window completes in the same cycle as an AVG_VALID&&AVG_READY handshake, the block SHALL load the new result, keep AVG_VALID=1, and leave OVERRUN unchanged.
REQ-027 OVERRUN SHALL clear on an edge with CLR_OVR=1. If a set condition and CLR_OVR occur on the same edge, set SHALL win.
REQ-028 When ENABLE falls mid-window, the partial window SHALL be discarded. The output register, AVG_VALID and OVERRUN SHALL be unaffected.
REQ-029 When IN_VALID arrives on the same edge that ENABLE falls, the sample SHALL be dropped.
REQ-030 For LOG2_N=0, every accepted sample SHALL complete a window, with AVG=AVG_MAX=AVG_MIN=IN_DATA.

Reset
REQ-031 Asserting rst low SHALL immediately, without waiting for a clock edge, force all outputs to these values:
- AVG, AVG_MAX and AVG_MIN = 0.
- AVG_VALID = 0, OVERRUN = 0, FILL = 0.
REQ-032 Asserting rst low SHALL also clear the accumulator, running max and running min, and place the block in IDLE.
REQ-033 Release of rst SHALL be sampled synchronously. The first sample SHALL be accepted no earlier than the second edge after release.
REQ-034 Reset mid-window SHALL discard the partial window, and the next window SHALL start from FILL=0.

Verification
REQ-035 Basic window: LOG2_N=2, ENABLE=1, samples 100, 200, 300, 400, AVG_READY=1 -> AVG=250, AVG_MAX=400, AVG_MIN=100, with AVG_VALID high exactly one cycle, one cycle after the 400 strobe.
REQ-036 Truncation and full scale:
- LOG2_N=1, samples 1, 2 -> AVG=1.
- LOG2_N=4, sixteen samples of 0xFFFF -> AVG=0xFFFF, with no wrap.
REQ-037 Overrun: LOG2_N=2, AVG_READY=0, eight samples of 10 then 20 -> AVG=10 retained, OVERRUN=1. Then CLR_OVR pulse -> OVERRUN=0.
REQ-038 Simultaneous handshake: assert AVG_READY in the cycle the second window completes -> the new AVG is loaded, AVG_VALID stays 1, OVERRUN=0.
REQ-039 Window interruption:
- ENABLE low after 2 of 4 samples, then 4 samples of 8 -> AVG=8, FILL returns to 0.
- Asynchronous rst low mid-window between clock edges -> all outputs 0 immediately.
REQ-040 Integration: connect to the AD7685 interface with CNV_START every 99 us and a bit-stream SDO -> AVG_VALID is asserted once per N VALID strobes.
